// File: rtl/decimal_result_formatter_pkg.sv
// Shared constants, state encoding and sizing helper for decimal_result_formatter.
package decimal_result_formatter_pkg;

    localparam logic [7:0] ASCII_ZERO    = 8'h30;
    localparam logic [7:0] ASCII_NEWLINE = 8'h0A;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DIVIDE = 2'd1,
        ST_STORE  = 2'd2
    } state_e;

    // Decimal digits of 2^width-1: floor(width*log10(2)) + 1 (2^width is never a power of ten).
    function automatic int unsigned decimal_digits(input int unsigned width);
        return (width * 30103) / 100000 + 1;
    endfunction

endpackage

// File: rtl/decimal_result_formatter_div10_serial.sv
// Bit-serial restoring divide-by-10: VALUE_WIDTH cycles from start_i to a valid quotient/remainder.
module decimal_result_formatter_div10_serial
    import decimal_result_formatter_pkg::*;
#(
    parameter int unsigned VALUE_WIDTH = 48
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start_i,
    input  logic [VALUE_WIDTH-1:0] dividend_i,
    output logic                   done_c,
    output logic [VALUE_WIDTH-1:0] quotient_o,
    output logic [3:0]             remainder_o
);

    localparam int unsigned CNT_W = $clog2(VALUE_WIDTH + 1);

    logic [VALUE_WIDTH-1:0] quo_q;
    logic [3:0]             rem_q;
    logic [CNT_W-1:0]       cnt_q;
    logic                   run_q;
    logic [4:0]             trial_c;
    logic                   ge_c;
    logic [3:0]             rem_next_c;

    assign trial_c    = {rem_q, quo_q[VALUE_WIDTH-1]};
    assign ge_c       = (trial_c >= 5'd10);
    assign rem_next_c = ge_c ? 4'(trial_c - 5'd10) : trial_c[3:0];

    // High during the final iteration; results are valid from the following cycle.
    assign done_c      = run_q && (cnt_q == CNT_W'(1));
    assign quotient_o  = quo_q;
    assign remainder_o = rem_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            quo_q <= '0;
            rem_q <= '0;
            cnt_q <= '0;
            run_q <= 1'b0;
        end else if (start_i) begin
            quo_q <= dividend_i;
            rem_q <= '0;
            cnt_q <= CNT_W'(VALUE_WIDTH);
            run_q <= 1'b1;
        end else if (run_q) begin
            quo_q <= {quo_q[VALUE_WIDTH-2:0], ge_c};
            rem_q <= rem_next_c;
            cnt_q <= cnt_q - CNT_W'(1);
            run_q <= (cnt_q != CNT_W'(1));
        end
    end

endmodule

// File: rtl/decimal_result_formatter.sv
// Binary-to-ASCII-decimal formatter feeding multiple_byte_sender.
// Optional trailing newline byte: define DECIMAL_RESULT_FORMATTER_NEWLINE_EN.
module decimal_result_formatter
    import decimal_result_formatter_pkg::*;
#(
    parameter int unsigned VALUE_WIDTH      = 48,
    parameter int unsigned MAX_BITS_TO_SEND = 128
) (
    input  logic                                      clk,
    input  logic                                      reset_n,
    input  logic                                      start,
    input  logic [VALUE_WIDTH-1:0]                    value,
    output logic                                      busy,
    output logic                                      new_data_to_send,
    output logic [MAX_BITS_TO_SEND-1:0]               data,
    output logic [$clog2(MAX_BITS_TO_SEND+1)-1:0]     number_of_bits_to_send
);

    localparam int unsigned MAX_DIGITS = decimal_digits(VALUE_WIDTH);
    localparam int unsigned BITS_W     = $clog2(MAX_BITS_TO_SEND + 1);
    localparam int unsigned CNT_W      = $clog2(MAX_DIGITS + 2);

`ifdef DECIMAL_RESULT_FORMATTER_NEWLINE_EN
    localparam logic [MAX_BITS_TO_SEND-1:0] SHIFT_PRELOAD = MAX_BITS_TO_SEND'(ASCII_NEWLINE);
    localparam int unsigned                 NL_BYTES      = 1;
`else
    localparam logic [MAX_BITS_TO_SEND-1:0] SHIFT_PRELOAD = '0;
    localparam int unsigned                 NL_BYTES      = 0;
`endif

    state_e                        state_q;
    logic                          busy_q;
    logic                          pulse_q;
    logic [MAX_BITS_TO_SEND-1:0]   data_q;
    logic [BITS_W-1:0]             bits_q;
    logic [MAX_BITS_TO_SEND-1:0]   shift_q;
    logic [CNT_W-1:0]              digit_cnt_q;

    logic                          div_start_c;
    logic [VALUE_WIDTH-1:0]        div_dividend_c;
    logic                          div_done_c;
    logic [VALUE_WIDTH-1:0]        quotient;
    logic [3:0]                    remainder;
    logic                          quotient_zero_c;
    logic [7:0]                    digit_byte_c;
    logic [MAX_BITS_TO_SEND-1:0]   shift_next_c;
    logic [31:0]                   bits_calc_c;

    assign quotient_zero_c = (quotient == '0);
    assign div_start_c     = ((state_q == ST_IDLE) && start) ||
                             ((state_q == ST_STORE) && !quotient_zero_c);
    assign div_dividend_c  = (state_q == ST_IDLE) ? value : quotient;
    assign digit_byte_c    = ASCII_ZERO + {4'b0000, remainder};
    // New digit enters byte 0; the oldest byte falls off the top.
    assign shift_next_c    = MAX_BITS_TO_SEND'({shift_q, digit_byte_c});
    assign bits_calc_c     = (32'(digit_cnt_q) + 32'd1 + 32'(NL_BYTES)) << 3;

    decimal_result_formatter_div10_serial #(
        .VALUE_WIDTH (VALUE_WIDTH)
    ) u_div10 (
        .clk         (clk),
        .rst_n       (reset_n),
        .start_i     (div_start_c),
        .dividend_i  (div_dividend_c),
        .done_c      (div_done_c),
        .quotient_o  (quotient),
        .remainder_o (remainder)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            busy_q      <= 1'b0;
            pulse_q     <= 1'b0;
            data_q      <= '0;
            bits_q      <= '0;
            shift_q     <= '0;
            digit_cnt_q <= '0;
        end else begin
            pulse_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        shift_q     <= SHIFT_PRELOAD;
                        digit_cnt_q <= '0;
                        busy_q      <= 1'b1;
                        state_q     <= ST_DIVIDE;
                    end
                end
                ST_DIVIDE: begin
                    if (div_done_c) begin
                        state_q <= ST_STORE;
                    end
                end
                ST_STORE: begin
                    shift_q     <= shift_next_c;
                    digit_cnt_q <= digit_cnt_q + CNT_W'(1);
                    if (!quotient_zero_c) begin
                        state_q <= ST_DIVIDE;
                    end else begin
                        data_q  <= shift_next_c;
                        bits_q  <= BITS_W'(bits_calc_c);
                        pulse_q <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy                   = busy_q;
    assign new_data_to_send       = pulse_q;
    assign data                   = data_q;
    assign number_of_bits_to_send = bits_q;

endmodule
